md_cart_mapper: RTL and testbench

Cartridge-side responder for the console cartridge bus: it decodes cart_cs/cart_oe/cart_lwr/cart_uwr/cart_time from the console model, drives cart_data back, and provides SSF2-style bank switching plus battery-backed save RAM. ROM contents sit in a backing store (SDRAM controller or block RAM) reached through a request/acknowledge port. The block sits at the board level, on the far side of the cartridge pins from the console.

---
 rtl/md_cart_mapper.sv | 156 +++++++++++++++
 tb/tb_md_cart_mapper.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/md_cart_mapper.sv
// md_cart_mapper -- cartridge-side responder for the console cartridge bus.
//
// Decodes the console's cartridge strobes, answers reads either from the
// battery-backed save RAM or from a ROM backing store reached through a
// level request / pulse acknowledge port, and implements SSF2-style
// 512 KB bank switching through the /TIME register window.
//
// Ports:
//   MCLK, SRES            clock; asynchronous active-low reset
//   cart_address[20:0]    68k word address A[21:1]
//   cart_cs, cart_oe      ROM-region select, read strobe
//   cart_lwr, cart_uwr    low / high byte write strobes
//   cart_time             /TIME region select (A130xxx)
//   cart_data_wr[15:0]    write data from the console
//   cart_data[15:0]       read data, held between accesses
//   rom_req, rom_addr     backing-store request (level) and word address
//   rom_ack, rom_rdata    one-cycle acknowledge with data
//   busy                  a ROM fetch is outstanding
module md_cart_mapper #(
  parameter int SRAM_AW = 13,
  parameter int BANK_W  = 6
) (
  input  logic        MCLK,
  input  logic        SRES,
  input  logic [20:0] cart_address,
  input  logic        cart_cs,
  input  logic        cart_oe,
  input  logic        cart_lwr,
  input  logic        cart_uwr,
  input  logic        cart_time,
  input  logic [15:0] cart_data_wr,
  output logic [15:0] cart_data,
  output logic        rom_req,
  output logic [23:0] rom_addr,
  input  logic        rom_ack,
  input  logic [15:0] rom_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;

  state_t state;

  // strobe levels and their registered copies for edge detection
  logic rd_lvl, wr_lvl, tw_lvl;
  logic rd_q, wr_q, tw_q;
  logic rd_edge, wr_edge, tw_edge;
  logic rd_start;

  // mapper configuration
  logic [BANK_W-1:0] bank_q [0:7];
  logic              sram_en, sram_wp;

  // save RAM (not reset: contents are battery-backed)
  logic [7:0]         sram_mem [0:(1<<SRAM_AW)-1];
  logic [SRAM_AW-1:0] sram_idx;
  logic [7:0]         sram_rd;
  logic               sram_hit, sram_we;

  logic [2:0]        slot;
  logic [BANK_W-1:0] bank_sel;
  logic [23:0]       phys_addr;
  logic              reg_wr;

  // upper write-data byte only matters when banks are wider than 8 bits
  logic unused_ok;
  assign unused_ok = &{1'b0, cart_data_wr[15:8]};

  assign rd_lvl  = cart_cs & cart_oe;
  assign wr_lvl  = cart_cs & (cart_lwr | cart_uwr);
  assign tw_lvl  = cart_time & (cart_lwr | cart_uwr);
  assign rd_edge = rd_lvl & ~rd_q;
  assign wr_edge = wr_lvl & ~wr_q;
  assign tw_edge = tw_lvl & ~tw_q;

  // a write strobe rising with oe owns the cycle; no read is issued
  assign rd_start = rd_edge & ~wr_edge;

  assign slot      = cart_address[20:18];
  assign bank_sel  = bank_q[slot];
  assign phys_addr = 24'({bank_sel, cart_address[17:0]});

  assign sram_hit = sram_en & (slot == 3'd4);
  assign sram_idx = cart_address[SRAM_AW-1:0];
  assign sram_rd  = sram_mem[sram_idx];
  assign sram_we  = wr_edge & sram_hit & cart_lwr & ~sram_wp;

  // register window is byte-wide on the odd byte: uwr-only writes ignored
  assign reg_wr = tw_edge & cart_lwr;

  // mapper registers; bank_q[0] is never written so slot 0 stays at bank 0
  always_ff @(posedge MCLK or negedge SRES) begin
    if (!SRES) begin
      for (int i = 0; i < 8; i++) bank_q[i] <= BANK_W'(i);
      sram_en <= 1'b0;
      sram_wp <= 1'b0;
    end else if (reg_wr && cart_address[6:3] == 4'hF) begin
      if (cart_address[2:0] == 3'd0) begin
        sram_en <= cart_data_wr[0];
        sram_wp <= cart_data_wr[1];
      end else begin
        bank_q[cart_address[2:0]] <= cart_data_wr[BANK_W-1:0];
      end
    end
  end

  always_ff @(posedge MCLK) begin
    if (sram_we) sram_mem[sram_idx] <= cart_data_wr[7:0];
  end

  // access state machine; all outputs registered here
  always_ff @(posedge MCLK or negedge SRES) begin
    if (!SRES) begin
      state     <= S_IDLE;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      tw_q      <= 1'b0;
      rom_req   <= 1'b0;
      rom_addr  <= '0;
      busy      <= 1'b0;
      cart_data <= 16'hFFFF;
    end else begin
      rd_q <= rd_lvl;
      wr_q <= wr_lvl;
      tw_q <= tw_lvl;
      case (state)
        S_IDLE: begin
          if (rd_start) begin
            if (sram_hit) begin
              cart_data <= {8'hFF, sram_rd};
            end else begin
              state    <= S_REQ;
              rom_req  <= 1'b1;
              busy     <= 1'b1;
              rom_addr <= phys_addr;
            end
          end
        end
        S_REQ: begin
          // a read abandoned by the console still completes its fetch
          if (rom_ack) begin
            cart_data <= rom_rdata;
            rom_req   <= 1'b0;
            busy      <= 1'b0;
            state     <= rd_lvl ? S_HOLD : S_IDLE;
          end
        end
        S_HOLD: begin
          if (!rd_lvl) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_cart_mapper.sv
module tb_md_cart_mapper;

  logic        MCLK = 1'b0;
  logic        SRES;
  logic [20:0] cart_address;
  logic        cart_cs, cart_oe, cart_lwr, cart_uwr, cart_time;
  logic [15:0] cart_data_wr;
  logic [15:0] cart_data;
  logic        rom_req;
  logic [23:0] rom_addr;
  logic        rom_ack;
  logic [15:0] rom_rdata;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  md_cart_mapper #(.SRAM_AW(13), .BANK_W(6)) dut (
    .MCLK(MCLK), .SRES(SRES),
    .cart_address(cart_address), .cart_cs(cart_cs), .cart_oe(cart_oe),
    .cart_lwr(cart_lwr), .cart_uwr(cart_uwr), .cart_time(cart_time),
    .cart_data_wr(cart_data_wr), .cart_data(cart_data),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack),
    .rom_rdata(rom_rdata), .busy(busy)
  );

  always #5 MCLK = ~MCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  // ROM read with ack returned dly cycles after the edge sample
  task automatic rom_read(input logic [20:0] a, input int dly, input logic [15:0] d,
                          input logic [23:0] exp_a, input string tag);
    int cnt;
    cart_address = a; cart_cs = 1'b1; cart_oe = 1'b1;
    tick();
    chk({tag, "_req"}, 32'(rom_req), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_addr"}, 32'(rom_addr), 32'(exp_a));
    cnt = 1;
    for (int i = 1; i < dly; i++) begin
      tick();
      cnt += int'(rom_req);
    end
    rom_ack = 1'b1; rom_rdata = d;
    tick();
    rom_ack = 1'b0; rom_rdata = 16'h0;
    chk({tag, "_reqcnt"}, 32'(cnt), 32'(dly));
    chk({tag, "_reqdrop"}, 32'(rom_req), 32'd0);
    chk({tag, "_data"}, 32'(cart_data), 32'(d));
    cart_cs = 1'b0; cart_oe = 1'b0;
    tick();
  endtask

  task automatic time_wr(input logic [6:0] off, input logic [15:0] d, input logic lwr, input logic uwr);
    cart_address = 21'h009800 | 21'(off); cart_data_wr = d;
    cart_time = 1'b1; cart_lwr = lwr; cart_uwr = uwr;
    tick();
    cart_time = 1'b0; cart_lwr = 1'b0; cart_uwr = 1'b0;
    tick();
  endtask

  task automatic cart_wr(input logic [20:0] a, input logic [15:0] d, input logic lwr,
                         input logic uwr, input string tag);
    cart_address = a; cart_data_wr = d;
    cart_cs = 1'b1; cart_lwr = lwr; cart_uwr = uwr;
    tick();
    chk({tag, "_noreq"}, 32'(rom_req), 32'd0);
    cart_cs = 1'b0; cart_lwr = 1'b0; cart_uwr = 1'b0;
    tick();
  endtask

  task automatic sram_read(input logic [20:0] a, input logic [15:0] exp, input string tag);
    cart_address = a; cart_cs = 1'b1; cart_oe = 1'b1;
    tick();
    chk({tag, "_data"}, 32'(cart_data), 32'(exp));
    chk({tag, "_noreq"}, 32'(rom_req), 32'd0);
    cart_cs = 1'b0; cart_oe = 1'b0;
    tick();
  endtask

  initial begin
    int cnt;
    SRES = 1'b0; cart_address = '0; cart_cs = 0; cart_oe = 0; cart_lwr = 0;
    cart_uwr = 0; cart_time = 0; cart_data_wr = '0; rom_ack = 0; rom_rdata = '0;
    tick(); tick();
    chk("rst_data", 32'(cart_data), 32'hFFFF);
    chk("rst_req", 32'(rom_req), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    SRES = 1'b1;
    tick();

    // 1: basic fetch, ack three cycles after the edge
    rom_read(21'h000010, 3, 16'h1234, 24'h000010, "t1");

    // stray ack while idle leaves cart_data alone
    rom_ack = 1'b1; rom_rdata = 16'h5555;
    tick();
    rom_ack = 1'b0;
    chk("stray_ack", 32'(cart_data), 32'h1234);

    // 2: banking; 32 x 512 KB = word 0x800000 (byte 0x1000000)
    rom_read(21'h1C0000, 1, 16'h0007, 24'h1C0000, "t2a");
    time_wr(7'h7F, 16'h0020, 1'b1, 1'b0);
    rom_read(21'h1C0000, 2, 16'h0020, 24'h800000, "t2b");
    time_wr(7'h7F, 16'h0003, 1'b0, 1'b1);   // uwr only: ignored
    rom_read(21'h1C0005, 1, 16'h0021, 24'h800005, "t2c");
    // register write followed by a read edge on the very next cycle
    cart_address = 21'h00987F; cart_data_wr = 16'h0005; cart_time = 1'b1; cart_lwr = 1'b1;
    tick();
    cart_time = 1'b0; cart_lwr = 1'b0;
    cart_address = 21'h1C0000; cart_cs = 1'b1; cart_oe = 1'b1;
    tick();
    chk("b2b_addr", 32'(rom_addr), 32'h140000);
    rom_ack = 1'b1; rom_rdata = 16'hB2B0;
    tick();
    rom_ack = 1'b0;
    chk("b2b_data", 32'(cart_data), 32'hB2B0);
    cart_cs = 1'b0; cart_oe = 1'b0;
    tick();

    // 3: save RAM
    time_wr(7'h78, 16'h0001, 1'b1, 1'b0);
    cart_wr(21'h100003, 16'h00A5, 1'b1, 1'b0, "t3w");
    chk("t3_wr_no_data", 32'(cart_data), 32'hB2B0);
    sram_read(21'h100003, 16'hFFA5, "t3r");
    sram_read(21'h102003, 16'hFFA5, "t3alias");
    cart_wr(21'h100003, 16'h0077, 1'b0, 1'b1, "t3uwr");
    sram_read(21'h100003, 16'hFFA5, "t3uwr_r");
    time_wr(7'h78, 16'h0003, 1'b1, 1'b0);
    cart_wr(21'h100003, 16'h005A, 1'b1, 1'b0, "t3wp");
    sram_read(21'h100003, 16'hFFA5, "t3wp_r");

    // write and read rising together: write wins, no read
    time_wr(7'h78, 16'h0001, 1'b1, 1'b0);
    cart_address = 21'h100005; cart_data_wr = 16'h003C;
    cart_cs = 1'b1; cart_oe = 1'b1; cart_lwr = 1'b1;
    tick();
    chk("prio_noreq", 32'(rom_req), 32'd0);
    chk("prio_data", 32'(cart_data), 32'hFFA5);
    cart_cs = 1'b0; cart_oe = 1'b0; cart_lwr = 1'b0;
    tick();
    sram_read(21'h100005, 16'hFF3C, "prio_r");
    cart_address = 21'h000500; cart_cs = 1'b1; cart_oe = 1'b1; cart_lwr = 1'b1;
    tick();
    chk("prio_rom_noreq", 32'(rom_req), 32'd0);
    chk("prio_rom_busy", 32'(busy), 32'd0);
    cart_cs = 1'b0; cart_oe = 1'b0; cart_lwr = 1'b0;
    tick();

    // 4: save RAM disabled
    time_wr(7'h78, 16'h0000, 1'b1, 1'b0);
    cart_wr(21'h100003, 16'h0011, 1'b1, 1'b0, "t4w");
    rom_read(21'h100003, 2, 16'hBEEF, 24'h100003, "t4r");
    time_wr(7'h78, 16'h0001, 1'b1, 1'b0);
    sram_read(21'h100003, 16'hFFA5, "t4keep");

    // 5: reset during REQ
    cart_address = 21'h000040; cart_cs = 1'b1; cart_oe = 1'b1;
    tick();
    chk("t5_req", 32'(rom_req), 32'd1);
    tick();
    SRES = 1'b0;
    #1;
    chk("t5_rst_req", 32'(rom_req), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_data", 32'(cart_data), 32'hFFFF);
    cart_cs = 1'b0; cart_oe = 1'b0;
    tick();
    SRES = 1'b1;
    rom_ack = 1'b1; rom_rdata = 16'hDEAD;
    tick();
    rom_ack = 1'b0;
    chk("t5_late_ack_req", 32'(rom_req), 32'd0);
    chk("t5_late_ack_data", 32'(cart_data), 32'hFFFF);
    rom_read(21'h1C0000, 1, 16'h4242, 24'h1C0000, "t5r");
    time_wr(7'h78, 16'h0001, 1'b1, 1'b0);
    sram_read(21'h100003, 16'hFFA5, "t5sram");

    // 6: held strobe never retriggers
    cart_address = 21'h000100; cart_cs = 1'b1; cart_oe = 1'b1;
    tick();
    rom_ack = 1'b1; rom_rdata = 16'h0F0F;
    tick();
    rom_ack = 1'b0;
    chk("t6_data", 32'(cart_data), 32'h0F0F);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt += int'(rom_req);
    end
    chk("t6_held_reqs", 32'(cnt), 32'd0);
    cart_cs = 1'b0; cart_oe = 1'b0;
    tick();

    // oe dropped while the fetch is pending
    cart_address = 21'h000200; cart_cs = 1'b1; cart_oe = 1'b1;
    tick();
    cart_cs = 1'b0; cart_oe = 1'b0;
    tick(); tick();
    chk("t6_pend_req", 32'(rom_req), 32'd1);
    rom_ack = 1'b1; rom_rdata = 16'hCAFE;
    tick();
    rom_ack = 1'b0;
    chk("t6_pend_data", 32'(cart_data), 32'hCAFE);
    chk("t6_pend_busy", 32'(busy), 32'd0);
    // straight back to IDLE: a read edge right away is accepted
    cart_address = 21'h000300; cart_cs = 1'b1; cart_oe = 1'b1;
    tick();
    chk("t6_next_req", 32'(rom_req), 32'd1);
    chk("t6_next_addr", 32'(rom_addr), 32'h000300);
    rom_ack = 1'b1; rom_rdata = 16'h0300;
    tick();
    rom_ack = 1'b0;
    chk("t6_next_data", 32'(cart_data), 32'h0300);
    cart_cs = 1'b0; cart_oe = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
